// File: rtl/edge_event_controller.sv
`timescale 1ns/1ps
// Purpose : sequences an edge detector, then measures one full input cycle
//           (high time and period, in clock cycles) with per-state timeout.
// Latency : result valid the cycle after the closing rising edge is sampled;
//           every output is registered.
// Backpr. : result and timeout flag held stable in DONE until valid_o && ready_i;
//           start_i is ignored (not queued) while busy.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start_i        one-cycle measurement request (honoured only in IDLE)
//   rising_edge_i  rising-edge pulse from the detector
//   falling_edge_i falling-edge pulse from the detector
//   det_en_o       detector enable, high from ARM through LOW
//   busy_o         high in every state except IDLE
//   high_cnt_o     measured high time
//   period_cnt_o   measured period
//   timeout_o      result qualifier: measurement aborted by the wait timer
//   valid_o        result available (DONE)
//   ready_i        consumer accepts the result
module edge_event_controller #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             rising_edge_i,
    input  logic             falling_edge_i,
    output logic             det_en_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] high_cnt_o,
    output logic [CNT_W-1:0] period_cnt_o,
    output logic             timeout_o,
    output logic             valid_o,
    input  logic             ready_i
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_HIGH      = 3'd3,
        S_LOW       = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    // The timer is compared against TIMEOUT-1: the abort happens on the edge
    // at which tmr would reach TIMEOUT, so a wait state lasts at most TIMEOUT
    // cycles. An expected edge on that same edge is checked first and wins.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Registered state
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_tmr;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_period;
    logic             r_timeout;
    logic             r_det_en;
    logic             r_busy;
    logic             r_valid;

    // Next-state values
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_tmr_nxt;
    logic [CNT_W-1:0] w_high_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic             w_timeout_nxt;

    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_tmr_inc;
    logic             w_tmr_expire;

    // cnt cannot wrap for legal TIMEOUT in HIGH, but HIGH+LOW together can
    // approach twice TIMEOUT, so saturate rather than wrap.
    assign w_cnt_inc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
    assign w_tmr_inc    = r_tmr + CNT_ONE;
    assign w_tmr_expire = (r_tmr == TMO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_tmr_nxt     = r_tmr;
        w_high_nxt    = r_high;
        w_period_nxt  = r_period;
        w_timeout_nxt = r_timeout;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_ARM;
                    w_tmr_nxt   = '0;
                end
            end

            // Detector has just been enabled; its first output carries
            // stale history, so both edge inputs are dropped here.
            S_ARM: begin
                w_state_nxt = S_WAIT_RISE;
                w_tmr_nxt   = '0;
            end

            S_WAIT_RISE: begin
                if (rising_edge_i) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = CNT_ONE;
                    w_tmr_nxt   = '0;
                end else if (w_tmr_expire) begin
                    w_state_nxt   = S_DONE;
                    w_timeout_nxt = 1'b1;
                    w_high_nxt    = '0;
                    w_period_nxt  = '0;
                    w_tmr_nxt     = '0;
                end else begin
                    w_tmr_nxt = w_tmr_inc;
                end
            end

            S_HIGH: begin
                if (falling_edge_i) begin
                    w_state_nxt = S_LOW;
                    w_high_nxt  = r_cnt;
                    w_cnt_nxt   = w_cnt_inc;
                    w_tmr_nxt   = '0;
                end else if (w_tmr_expire) begin
                    w_state_nxt   = S_DONE;
                    w_timeout_nxt = 1'b1;
                    w_high_nxt    = '0;
                    w_period_nxt  = '0;
                    w_tmr_nxt     = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_tmr_nxt = w_tmr_inc;
                end
            end

            S_LOW: begin
                if (rising_edge_i) begin
                    w_state_nxt   = S_DONE;
                    w_period_nxt  = r_cnt;
                    w_timeout_nxt = 1'b0;
                    w_tmr_nxt     = '0;
                end else if (w_tmr_expire) begin
                    w_state_nxt   = S_DONE;
                    w_timeout_nxt = 1'b1;
                    w_high_nxt    = '0;
                    w_period_nxt  = '0;
                    w_tmr_nxt     = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_tmr_nxt = w_tmr_inc;
                end
            end

            // valid_o is high for the whole of DONE, so ready_i alone
            // completes the transfer here.
            S_DONE: begin
                if (ready_i) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b0;
                    w_tmr_nxt     = '0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_tmr_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, results and registered status outputs. Status flags are
    // decoded from the next state so they line up with the state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_tmr     <= '0;
            r_high    <= '0;
            r_period  <= '0;
            r_timeout <= 1'b0;
            r_det_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_tmr     <= w_tmr_nxt;
            r_high    <= w_high_nxt;
            r_period  <= w_period_nxt;
            r_timeout <= w_timeout_nxt;
            r_det_en  <= (w_state_nxt inside {S_ARM, S_WAIT_RISE, S_HIGH, S_LOW});
            r_busy    <= (w_state_nxt != S_IDLE);
            r_valid   <= (w_state_nxt == S_DONE);
        end
    end

    assign det_en_o     = r_det_en;
    assign busy_o       = r_busy;
    assign high_cnt_o   = r_high;
    assign period_cnt_o = r_period;
    assign timeout_o    = r_timeout;
    assign valid_o      = r_valid;

endmodule

// File: tb/tb_edge_event_controller.sv
`timescale 1ns/1ps
module tb_edge_event_controller;

    localparam int CNT_W = 16;
    localparam int TMO   = 20;

    logic             clk = 1'b0;
    logic             reset;
    logic             start_i;
    logic             rising_edge_i;
    logic             falling_edge_i;
    logic             ready_i;
    logic             det_en_o;
    logic             busy_o;
    logic [CNT_W-1:0] high_cnt_o;
    logic [CNT_W-1:0] period_cnt_o;
    logic             timeout_o;
    logic             valid_o;

    int n_run  = 0;
    int n_fail = 0;

    edge_event_controller #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .rising_edge_i  (rising_edge_i),
        .falling_edge_i (falling_edge_i),
        .det_en_o       (det_en_o),
        .busy_o         (busy_o),
        .high_cnt_o     (high_cnt_o),
        .period_cnt_o   (period_cnt_o),
        .timeout_o      (timeout_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i)
    );

    always #5 clk = ~clk;

    // Reference model: each wait state (WAIT_RISE, HIGH, LOW) may last at most
    // TMO cycles; an edge landing exactly on the TMO-th cycle is still honoured.
    // Edge numbering: edge 0 samples start_i, edge 1 is ARM, wait starts at 1.
    // a  = cycles from ARM edge to first rise, h = rise->fall, lo = fall->rise.
    task automatic run_meas(input int a, input int h, input int lo, input int rdly,
                            input bit noise, input string tag);
        int t0, t1, t2, done_e, exp_hi, exp_per;
        bit exp_to;
        logic [2:0] st;

        n_run++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_before_start: busy got %b expected 0", tag, busy_o);
        end

        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        n_run++;
        st = {busy_o, det_en_o, valid_o};
        if (st !== 3'b110) begin
            n_fail++;
            $display("FAIL %s after_start busy/det_en/valid: got %b expected 110", tag, st);
        end

        t0 = 1 + a;
        t1 = t0 + h;
        t2 = t1 + lo;
        if (a > TMO) begin
            done_e = 1 + TMO; exp_to = 1'b1; exp_hi = 0; exp_per = 0;
        end else if (h > TMO) begin
            done_e = t0 + TMO; exp_to = 1'b1; exp_hi = 0; exp_per = 0;
        end else if (lo > TMO) begin
            done_e = t1 + TMO; exp_to = 1'b1; exp_hi = 0; exp_per = 0;
        end else begin
            done_e = t2; exp_to = 1'b0; exp_hi = h; exp_per = h + lo;
        end

        for (int e = 1; e <= done_e; e++) begin
            rising_edge_i  = (e == t0) || (e == t2) || (noise && e == 1) ||
                             (noise && h >= 2 && e == t0 + 1);
            falling_edge_i = (e == t1) || (noise && e == 1) ||
                             (noise && a >= 2 && e == 2) ||
                             (noise && lo >= 2 && e == t1 + 1);
            start_i        = noise && ($urandom_range(0, 3) == 0);
            ready_i        = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (e < done_e) begin
                n_run++;
                st = {busy_o, det_en_o, valid_o};
                if (st !== 3'b110) begin
                    n_fail++;
                    $display("FAIL %s measuring e=%0d busy/det_en/valid: got %b expected 110",
                             tag, e, st);
                end
            end
        end
        rising_edge_i  = 1'b0;
        falling_edge_i = 1'b0;
        start_i        = 1'b0;

        // Result presented and held for rdly backpressured cycles
        for (int j = 0; j <= rdly; j++) begin
            n_run++;
            st = {busy_o, det_en_o, valid_o};
            if (st !== 3'b101 || timeout_o !== exp_to ||
                high_cnt_o !== CNT_W'(exp_hi) || period_cnt_o !== CNT_W'(exp_per)) begin
                n_fail++;
                $display("FAIL %s result hold=%0d: got st=%b to=%b hi=%0d per=%0d expected st=101 to=%b hi=%0d per=%0d",
                         tag, j, st, timeout_o, high_cnt_o, period_cnt_o, exp_to, exp_hi, exp_per);
            end
            ready_i = (j == rdly);
            @(posedge clk); #1;
        end
        ready_i = 1'b0;

        n_run++;
        st = {busy_o, det_en_o, valid_o};
        if (st !== 3'b000 || timeout_o !== 1'b0 ||
            high_cnt_o !== CNT_W'(exp_hi) || period_cnt_o !== CNT_W'(exp_per)) begin
            n_fail++;
            $display("FAIL %s after_transfer: got st=%b to=%b hi=%0d per=%0d expected st=000 to=0 hi=%0d per=%0d",
                     tag, st, timeout_o, high_cnt_o, period_cnt_o, exp_hi, exp_per);
        end
    endtask

    task automatic test_reset();
        logic [2*CNT_W+3:0] o;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rising_edge_i  = 1'($urandom_range(0, 1));
            falling_edge_i = 1'($urandom_range(0, 1));
            ready_i        = 1'($urandom_range(0, 1));
            if (i == 5) reset = 1'b1;
            @(posedge clk); #1;
            o = {det_en_o, busy_o, valid_o, timeout_o, high_cnt_o, period_cnt_o};
            n_run++;
            if (o !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d: outputs got %h expected 0", i, o);
            end
        end
        rising_edge_i  = 1'b0;
        falling_edge_i = 1'b0;
        ready_i        = 1'b0;
    endtask

    task automatic test_nominal();
        run_meas(3, 4, 6, 0, 1'b0, "nominal");
    endtask

    task automatic test_backpressure();
        run_meas(3, 4, 6, 5, 1'b0, "backpressure");
    endtask

    task automatic test_timeout();
        run_meas(2, 25, 5, 0, 1'b0, "timeout_high");
        run_meas(25, 3, 5, 1, 1'b0, "timeout_wait_rise");
        run_meas(2, 3, 30, 2, 1'b0, "timeout_low");
        run_meas(TMO, TMO, TMO, 0, 1'b0, "edge_wins_boundary");
    endtask

    task automatic test_ignored();
        run_meas(3, 4, 6, 0, 1'b1, "ignored_events");
    endtask

    task automatic test_back_to_back();
        run_meas(1, 1, 1, 0, 1'b0, "b2b_min_a");
        run_meas(1, 2, 1, 0, 1'b1, "b2b_min_b");
    endtask

    task automatic test_reset_mid();
        logic [2*CNT_W+3:0] o;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            rising_edge_i  = (e == 3);
            falling_edge_i = (e == 6);
            @(posedge clk); #1;
        end
        rising_edge_i  = 1'b0;
        falling_edge_i = 1'b0;
        n_run++;
        if (high_cnt_o !== CNT_W'(3) || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_precond: got hi=%0d busy=%b expected hi=3 busy=1",
                     high_cnt_o, busy_o);
        end
        #2 reset = 1'b0;
        #1;
        o = {det_en_o, busy_o, valid_o, timeout_o, high_cnt_o, period_cnt_o};
        n_run++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: outputs got %h expected 0", o);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        run_meas(2, 3, 8, 1, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_meas(int'($urandom_range(1, 24)), int'($urandom_range(1, 24)),
                     int'($urandom_range(1, 24)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        reset          = 1'b0;
        start_i        = 1'b0;
        rising_edge_i  = 1'b0;
        falling_edge_i = 1'b0;
        ready_i        = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_timeout();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d of %0d failed so far",
                 n_fail, n_run);
        $fatal(1, "watchdog");
    end

endmodule
